// File: rtl/wb_uart_poller.sv
// Wishbone initiator that polls a wb_uart register slave and bridges it to local byte streams.
// Define WB_UART_POLLER_STATS_EN to build the rx/tx byte counters; otherwise they read as zero.
module wb_uart_poller #(
    parameter logic [31:0] UART_BASE = 32'h0000_0000,
    parameter int unsigned POLL_GAP  = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic [7:0]  tx_byte,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        uart_err,
    input  logic        err_clr,
    output logic        bus_err,
    output logic [15:0] rx_count,
    output logic [15:0] tx_count
);

    localparam int unsigned    GW        = $clog2(POLL_GAP + 1);
    localparam int unsigned    TW        = $clog2(TIMEOUT);
    localparam logic [GW-1:0]  GAP_LOAD  = GW'(POLL_GAP);
    localparam logic [TW-1:0]  TMR_LAST  = TW'(TIMEOUT - 1);
    localparam logic [31:0]    DATA_ADR  = UART_BASE + 32'd4;

    // UCR bit positions in the slave's control/status register
    localparam int UCR_RX_AVAIL = 0;
    localparam int UCR_RX_ERR   = 1;
    localparam int UCR_TX_BUSY  = 4;

    typedef enum logic [1:0] {S_GAP, S_POLL, S_RD, S_WR} state_t;

    state_t         state;
    logic [GW-1:0]  gap_cnt;
    logic [TW-1:0]  tmr;
    logic           tx_full;
    logic [7:0]     tx_hold;
    logic           bus_ack;
    logic           unused_bits;

    assign wb_stb_o = wb_cyc_o;
    assign wb_sel_o = 4'b0001;
    assign tx_ready = ~tx_full;
    // A stray ack while no cycle is open must not be mistaken for a completion.
    assign bus_ack  = wb_cyc_o & wb_ack_i;
    assign unused_bits = ^{wb_dat_i[31:8], wb_dat_i[7:5], wb_dat_i[3:2]};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_GAP;
            gap_cnt  <= GAP_LOAD;
            tmr      <= '0;
            wb_cyc_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            tx_full  <= 1'b0;
            tx_hold  <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            uart_err <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            if (tx_valid && !tx_full) begin
                tx_full <= 1'b1;
                tx_hold <= tx_byte;
            end
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            case (state)
                S_GAP: begin
                    if (gap_cnt <= GW'(1)) begin
                        state    <= S_POLL;
                        wb_cyc_o <= 1'b1;
                        wb_we_o  <= 1'b0;
                        wb_adr_o <= UART_BASE;
                        wb_dat_o <= '0;
                        tmr      <= '0;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: begin
                    if (!wb_cyc_o) begin
                        // Entered RD/WR one cycle after the poll ended; open the data cycle now.
                        wb_cyc_o <= 1'b1;
                        wb_we_o  <= (state == S_WR);
                        wb_adr_o <= DATA_ADR;
                        wb_dat_o <= (state == S_WR) ? {24'h0, tx_hold} : 32'h0;
                        tmr      <= '0;
                    end else if (wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        state    <= S_GAP;
                        gap_cnt  <= GAP_LOAD;
                        case (state)
                            S_POLL: begin
                                if (wb_dat_i[UCR_RX_ERR])
                                    uart_err <= 1'b1;
                                if (wb_dat_i[UCR_RX_AVAIL] && !rx_valid)
                                    state <= S_RD;
                                else if (tx_full && !wb_dat_i[UCR_TX_BUSY])
                                    state <= S_WR;
                            end
                            S_RD: begin
                                rx_byte  <= wb_dat_i[7:0];
                                rx_valid <= 1'b1;
                            end
                            S_WR:    tx_full <= 1'b0;
                            default: ;
                        endcase
                    end else if (tmr == TMR_LAST) begin
                        // Abandon the cycle; a held tx byte stays put and is retried later.
                        wb_cyc_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        bus_err  <= 1'b1;
                        state    <= S_GAP;
                        gap_cnt  <= GAP_LOAD;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
            endcase

            // Placed last so a clear overrides a same-cycle error report.
            if (err_clr)
                uart_err <= 1'b0;
        end
    end

`ifdef WB_UART_POLLER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_count <= '0;
            tx_count <= '0;
        end else begin
            if (bus_ack && state == S_RD)
                rx_count <= rx_count + 16'd1;
            if (bus_ack && state == S_WR)
                tx_count <= tx_count + 16'd1;
        end
    end
`else
    assign rx_count = 16'h0;
    assign tx_count = 16'h0;
`endif

endmodule
